// File: rtl/pc_sequencer.sv
// Strobe sequencer for the 16-bit PC register: fetch (address + increment), jump (byte loads), save (byte reads).
// Optional macro PC_WRAP_HALT_EN: a fetch that would wrap the PC past all-ones halts instead of incrementing.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module pc_sequencer #(
    parameter int DATA_WIDTH    = `DATA_WIDTH,
    parameter int ADDR_WIDTH    = 2 * DATA_WIDTH,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic fetch_req,
    input  logic jump_req,
    input  logic save_req,
    input  logic mem_rdy,
    input  logic pc_carry,
    output logic fetch_ack,
    output logic fetch_err,
    output logic jump_ack,
    output logic save_ack,
    output logic byte_sel,
    output logic pc_cs,
    output logic pc_oe_a,
    output logic pc_cnt_en,
    output logic pc_we_l,
    output logic pc_we_h,
    output logic pc_oe_l,
    output logic pc_oe_h,
    output logic halted
);
    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);
    // byte_sel carries the index of the top byte during the second bus phase.
    localparam logic HIGH_BYTE = 1'(ADDR_WIDTH / DATA_WIDTH - 1);

`ifdef PC_WRAP_HALT_EN
    typedef enum logic [2:0] {IDLE, FETCH, INCR, LOAD_L, LOAD_H, SAVE_L, SAVE_H, HALT} state_t;
    localparam state_t WRAP_STATE = HALT;
`else
    typedef enum logic [2:0] {IDLE, FETCH, INCR, LOAD_L, LOAD_H, SAVE_L, SAVE_H} state_t;
    localparam state_t WRAP_STATE = IDLE;
`endif

    typedef struct packed {
        logic fetch_ack;
        logic fetch_err;
        logic jump_ack;
        logic save_ack;
        logic byte_sel;
        logic cs;
        logic oe_a;
        logic cnt_en;
        logic we_l;
        logic we_h;
        logic oe_l;
        logic oe_h;
        logic halted;
    } outs_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    outs_t            outs_q, outs_d;
    logic             wrap_now;

`ifdef PC_WRAP_HALT_EN
    assign wrap_now = pc_carry;
`else
    logic unused_carry;
    assign unused_carry = pc_carry;
    assign wrap_now     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        outs_d  = '0;

        case (state_q)
            IDLE: begin
                // A fetch_err pulse is still visible to the requester this cycle, so its
                // held request must not start a new fetch yet.
                if (jump_req)
                    state_d = LOAD_L;
                else if (save_req)
                    state_d = SAVE_L;
                else if (fetch_req && !outs_q.fetch_err)
                    state_d = FETCH;
            end
            FETCH: begin
                if (mem_rdy) begin
                    state_d = INCR;
                    wrap_d  = wrap_now;
                end else if (cnt_q == CNT_LAST) begin
                    state_d          = IDLE;
                    outs_d.fetch_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            INCR:    state_d = wrap_q ? WRAP_STATE : IDLE;
            LOAD_L:  state_d = LOAD_H;
            LOAD_H:  state_d = IDLE;
            SAVE_L:  state_d = SAVE_H;
            SAVE_H:  state_d = IDLE;
`ifdef PC_WRAP_HALT_EN
            HALT:    state_d = HALT;
`endif
            default: state_d = IDLE;
        endcase

        if (state_d != FETCH)
            cnt_d = '0;

        // Outputs are decoded from the next state so they appear registered, aligned with the state.
        case (state_d)
            FETCH: begin
                outs_d.cs   = 1'b1;
                outs_d.oe_a = 1'b1;
            end
            INCR: begin
                outs_d.cs        = 1'b1;
                outs_d.oe_a      = 1'b1;
                outs_d.cnt_en    = !wrap_d;
                outs_d.fetch_ack = 1'b1;
            end
            LOAD_L: begin
                outs_d.cs       = 1'b1;
                outs_d.we_l     = 1'b1;
                outs_d.byte_sel = ~HIGH_BYTE;
            end
            LOAD_H: begin
                outs_d.cs       = 1'b1;
                outs_d.we_h     = 1'b1;
                outs_d.byte_sel = HIGH_BYTE;
                outs_d.jump_ack = 1'b1;
            end
            SAVE_L: begin
                outs_d.cs       = 1'b1;
                outs_d.oe_l     = 1'b1;
                outs_d.byte_sel = ~HIGH_BYTE;
            end
            SAVE_H: begin
                outs_d.cs       = 1'b1;
                outs_d.oe_h     = 1'b1;
                outs_d.byte_sel = HIGH_BYTE;
                outs_d.save_ack = 1'b1;
            end
`ifdef PC_WRAP_HALT_EN
            HALT:    outs_d.halted = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            outs_q  <= outs_d;
        end
    end

    assign fetch_ack = outs_q.fetch_ack;
    assign fetch_err = outs_q.fetch_err;
    assign jump_ack  = outs_q.jump_ack;
    assign save_ack  = outs_q.save_ack;
    assign byte_sel  = outs_q.byte_sel;
    assign pc_cs     = outs_q.cs;
    assign pc_oe_a   = outs_q.oe_a;
    assign pc_cnt_en = outs_q.cnt_en;
    assign pc_we_l   = outs_q.we_l;
    assign pc_we_h   = outs_q.we_h;
    assign pc_oe_l   = outs_q.oe_l;
    assign pc_oe_h   = outs_q.oe_h;
    assign halted    = outs_q.halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register and an ack scoreboard.
// Expectations follow PC_WRAP_HALT_EN when the bench is built with it.
module tb_pc_sequencer;
    localparam logic [1:0] K_FACK = 2'd0;
    localparam logic [1:0] K_FERR = 2'd1;
    localparam logic [1:0] K_JACK = 2'd2;
    localparam logic [1:0] K_SACK = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] pc;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } exp_t;

    logic clk = 1'b0;
    logic reset, fetch_req, jump_req, save_req, mem_rdy, pc_carry;
    logic fetch_ack, fetch_err, jump_ack, save_ack, byte_sel;
    logic pc_cs, pc_oe_a, pc_cnt_en, pc_we_l, pc_we_h, pc_oe_l, pc_oe_h, halted;

    logic [15:0] pc_model = 16'h0000;
    logic [15:0] jump_tgt = 16'h0000;
    logic [7:0]  data_bus;
    logic [12:0] outs_vec;

    exp_t       sb[$];
    logic [7:0] save_bytes[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         oe_a_cnt, cnt_en_cnt;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .jump_req(jump_req), .save_req(save_req),
        .mem_rdy(mem_rdy), .pc_carry(pc_carry),
        .fetch_ack(fetch_ack), .fetch_err(fetch_err), .jump_ack(jump_ack), .save_ack(save_ack),
        .byte_sel(byte_sel), .pc_cs(pc_cs), .pc_oe_a(pc_oe_a), .pc_cnt_en(pc_cnt_en),
        .pc_we_l(pc_we_l), .pc_we_h(pc_we_h), .pc_oe_l(pc_oe_l), .pc_oe_h(pc_oe_h),
        .halted(halted)
    );

    // The requester puts the jump target byte selected by byte_sel on the bus.
    assign data_bus = byte_sel ? jump_tgt[15:8] : jump_tgt[7:0];
    assign pc_carry = &pc_model;
    assign outs_vec = {fetch_ack, fetch_err, jump_ack, save_ack, byte_sel, pc_cs, pc_oe_a,
                       pc_cnt_en, pc_we_l, pc_we_h, pc_oe_l, pc_oe_h, halted};

    always @(posedge clk) begin
        if (pc_cs && pc_cnt_en) pc_model <= pc_model + 16'd1;
        if (pc_cs && pc_we_l)   pc_model[7:0]  <= data_bus;
        if (pc_cs && pc_we_h)   pc_model[15:8] <= data_bus;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("strobe_exclusive", 32'($countones({pc_we_l, pc_we_h, pc_oe_l, pc_oe_h, pc_cnt_en}) <= 1), 1);
    end

    task automatic push(input logic [1:0] k, input logic [15:0] pc,
                        input logic [7:0] b0 = 8'h00, input logic [7:0] b1 = 8'h00);
        exp_t e;
        e.kind = k; e.pc = pc; e.b0 = b0; e.b1 = b1;
        sb.push_back(e);
    endtask

    // Plays the requester/memory side until all raised requests are acked (or budget runs out).
    task automatic run_ops(input int rdy_after, input int budget);
        int         fcyc;
        int         c;
        bit         pend;
        exp_t       cur;
        logic [1:0] got;
        fcyc = 0; c = 0; pend = 0;
        oe_a_cnt = 0; cnt_en_cnt = 0;
        save_bytes.delete();
        while ((jump_req || save_req || fetch_req || pend) && c < budget) begin
            @(negedge clk);
            c++;
            if (pend) begin
                pend = 0;
                chk("idle_gap_cs", pc_cs, 0);
                chk("pc_after_op", pc_model, cur.pc);
                if (cur.kind == K_SACK) begin
                    chk("save_nbytes", save_bytes.size(), 2);
                    if (save_bytes.size() == 2) begin
                        chk("save_byte_lo", save_bytes[0], cur.b0);
                        chk("save_byte_hi", save_bytes[1], cur.b1);
                    end
                end
            end
            if (pc_oe_a)   oe_a_cnt++;
            if (pc_cnt_en) cnt_en_cnt++;
            if (pc_oe_l || pc_oe_h) save_bytes.push_back(pc_oe_h ? pc_model[15:8] : pc_model[7:0]);
            if (pc_oe_a && !pc_cnt_en) fcyc++;
            mem_rdy = (rdy_after >= 0) && pc_oe_a && !pc_cnt_en && (fcyc == rdy_after + 1);
            if (fetch_ack || fetch_err || jump_ack || save_ack) begin
                got = fetch_ack ? K_FACK : fetch_err ? K_FERR : jump_ack ? K_JACK : K_SACK;
                chk("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    chk("ack_kind", got, cur.kind);
                    pend = 1;
                end
                if (jump_ack) jump_req = 0;
                if (save_ack) save_req = 0;
                if (fetch_ack || fetch_err) begin
                    fetch_req = 0;
                    fcyc = 0;
                end
            end
        end
        chk("ops_finished", {pend, jump_req, save_req, fetch_req}, 0);
        jump_req = 0; save_req = 0; fetch_req = 0; mem_rdy = 0;
    endtask

    initial begin
        int c;
        reset = 1; fetch_req = 0; jump_req = 0; save_req = 0; mem_rdy = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs_vec, 0);
        reset = 0;
        @(negedge clk);
        chk("idle_outs", outs_vec, 0);
        $display("txn reset: outputs cleared");

        jump_tgt = 16'h0010; push(K_JACK, 16'h0010); jump_req = 1;
        run_ops(-1, 10);
        $display("txn jump 0x0010: pc=%04h", pc_model);

        push(K_FACK, 16'h0011); fetch_req = 1;
        run_ops(3, 20);
        chk("fetch_oe_a_cycles", oe_a_cnt, 5);
        chk("fetch_cnt_en_cycles", cnt_en_cnt, 1);
        $display("txn fetch wait=3: pc=%04h oe_a=%0d", pc_model, oe_a_cnt);

        push(K_FERR, 16'h0011); fetch_req = 1;
        run_ops(-1, 30);
        chk("timeout_oe_a_cycles", oe_a_cnt, 15);
        chk("timeout_cnt_en_cycles", cnt_en_cnt, 0);
        $display("txn fetch timeout: pc=%04h fetch cycles=%0d", pc_model, oe_a_cnt);

        jump_tgt = 16'h12AB;
        push(K_JACK, 16'h12AB);
        push(K_SACK, 16'h12AB, 8'hAB, 8'h12);
        push(K_FACK, 16'h12AC);
        jump_req = 1; save_req = 1; fetch_req = 1;
        run_ops(0, 40);
        chk("sb_drained", sb.size(), 0);
        $display("txn jump+save+fetch: pc=%04h", pc_model);

        jump_tgt = 16'h00FF; push(K_JACK, 16'h00FF); jump_req = 1;
        run_ops(-1, 10);
        push(K_FACK, 16'h0100); fetch_req = 1;
        run_ops(1, 20);
        $display("txn fetch carry 0x00FF: pc=%04h", pc_model);

        // Reset lands on the edge that would enter LOAD_H: the high byte must never be written.
        jump_tgt = 16'hBEEF; jump_req = 1;
        c = 0;
        while (c < 8) begin
            @(negedge clk);
            c++;
            if (pc_we_l) break;
        end
        chk("reached_load_l", pc_we_l, 1);
        reset = 1;
        @(negedge clk);
        chk("rst_mid_jump_outs", outs_vec, 0);
        reset = 0; jump_req = 0;
        repeat (3) begin
            @(negedge clk);
            chk("no_ack_after_rst", {jump_ack, pc_cs}, 0);
        end
        chk("pc_hi_unchanged", pc_model, 16'h01EF);
        $display("txn reset mid-jump: pc=%04h", pc_model);

        jump_tgt = 16'hFFFF; push(K_JACK, 16'hFFFF); jump_req = 1;
        run_ops(-1, 10);
`ifdef PC_WRAP_HALT_EN
        push(K_FACK, 16'hFFFF); fetch_req = 1;
        run_ops(0, 20);
        chk("wrap_cnt_en_cycles", cnt_en_cnt, 0);
        chk("halted_set", halted, 1);
        fetch_req = 1;
        repeat (10) begin
            @(negedge clk);
            chk("halted_no_ack", {fetch_ack, fetch_err, pc_cs}, 0);
        end
        fetch_req = 0;
        chk("halted_held", halted, 1);
        $display("txn fetch at 0xFFFF: halted pc=%04h", pc_model);
`else
        push(K_FACK, 16'h0000); fetch_req = 1;
        run_ops(0, 20);
        chk("wrap_cnt_en_cycles", cnt_en_cnt, 1);
        chk("halted_low", halted, 0);
        $display("txn fetch at 0xFFFF: wrapped pc=%04h", pc_model);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
